// File: rtl/afg_dds_pkg.sv
// Shared types and default widths for the function-generator DDS phase accumulator.
package afg_dds_pkg;

    localparam int unsigned ACC_W_DEF = 32;
    localparam int unsigned OUT_W_DEF = 12;

    typedef enum logic [0:0] {
        IDLE,
        PENDING
    } ftw_state_e;

endpackage

// File: rtl/phase_acc_dds_if.sv
// FTW load handshake: master offers a tuning word, slave accepts it when ready.
interface phase_acc_dds_if
    import afg_dds_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) ();

    logic [ACC_W-1:0] ftw_in;
    logic             ftw_valid;
    logic             ftw_ready;

    modport master (output ftw_in, output ftw_valid, input ftw_ready);
    modport slave  (input ftw_in, input ftw_valid, output ftw_ready);

endinterface

// File: rtl/dds_ftw_ctrl.sv
// FTW handshake FSM: latches a pending tuning word and swaps it into the active FTW
// either on the next edge or at the next accumulator wrap, depending on APPLY_AT_WRAP.
module dds_ftw_ctrl
    import afg_dds_pkg::*;
#(
    parameter int unsigned ACC_W         = ACC_W_DEF,
    parameter bit          APPLY_AT_WRAP = 1'b1
) (
    input  logic             Clock,
    input  logic             rst,
    input  logic             en,
    input  logic             carry,
    input  logic [ACC_W-1:0] ftw_in,
    input  logic             ftw_valid,
    output logic             ftw_ready,
    output logic [ACC_W-1:0] ftw_active
);

    ftw_state_e       state_q, state_d;
    logic [ACC_W-1:0] pend_q, pend_d;
    logic [ACC_W-1:0] active_q, active_d;
    logic             apply;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        active_d  = active_q;
        ftw_ready = (state_q == IDLE);
        // A zero FTW never wraps, so waiting for a wrap would deadlock.
        apply     = !APPLY_AT_WRAP || (active_q == '0) || (en && carry);
        unique case (state_q)
            IDLE: begin
                if (ftw_valid) begin
                    pend_d  = ftw_in;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (apply) begin
                    active_d = pend_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (rst) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            active_q <= active_d;
        end
    end

    assign ftw_active = active_q;

endmodule

// File: rtl/phase_acc_dds.sv
// Modulo-2^ACC_W phase accumulator with wrap pulse and truncated phase output.
// Optional PHASE_OFFSET_EN adds a phase_offset port added to the truncated phase.
module phase_acc_dds
    import afg_dds_pkg::*;
#(
    parameter int unsigned ACC_W         = ACC_W_DEF,
    parameter int unsigned OUT_W         = OUT_W_DEF,
    parameter bit          APPLY_AT_WRAP = 1'b1
) (
    input  logic             Clock,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    phase_acc_dds_if.slave   ftw_if,
`ifdef PHASE_OFFSET_EN
    input  logic [OUT_W-1:0] phase_offset,
`endif
    output logic [ACC_W-1:0] ftw_active,
    output logic [ACC_W-1:0] acc_out,
    output logic             wrap,
    output logic [OUT_W-1:0] phase_out,
    output logic             phase_valid
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             wrap_q, wrap_d;
    logic             en_q, en_d;
    logic [OUT_W-1:0] phase_q, phase_d;
    logic             phase_valid_q, phase_valid_d;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             ftw_ready;

    assign sum   = {1'b0, acc_q} + {1'b0, ftw_active};
    assign carry = sum[ACC_W];

    // A cleared cycle is not a wrap, so it must not release a pending FTW.
    dds_ftw_ctrl #(
        .ACC_W        (ACC_W),
        .APPLY_AT_WRAP(APPLY_AT_WRAP)
    ) u_ftw_ctrl (
        .Clock     (Clock),
        .rst       (rst),
        .en        (en),
        .carry     (carry & ~clr),
        .ftw_in    (ftw_if.ftw_in),
        .ftw_valid (ftw_if.ftw_valid),
        .ftw_ready (ftw_ready),
        .ftw_active(ftw_active)
    );

    assign ftw_if.ftw_ready = ftw_ready;

    always_comb begin
        acc_d         = acc_q;
        wrap_d        = 1'b0;
        en_d          = en;
        phase_valid_d = en_q;
        phase_d       = acc_q[ACC_W-1 -: OUT_W];
`ifdef PHASE_OFFSET_EN
        phase_d       = acc_q[ACC_W-1 -: OUT_W] + phase_offset;
`endif
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d  = sum[ACC_W-1:0];
            wrap_d = carry;
        end
    end

    always_ff @(posedge Clock) begin
        if (rst) begin
            acc_q         <= '0;
            wrap_q        <= 1'b0;
            en_q          <= 1'b0;
            phase_q       <= '0;
            phase_valid_q <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            wrap_q        <= wrap_d;
            en_q          <= en_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
        end
    end

    assign acc_out     = acc_q;
    assign wrap        = wrap_q;
    assign phase_out   = phase_q;
    assign phase_valid = phase_valid_q;

endmodule

// File: tb/tb_phase_acc_dds.sv
// Two DUTs (apply-at-wrap and apply-immediately) driven identically and checked
// every cycle against a behavioural model, plus directed constant checks.
module tb_phase_acc_dds;

    localparam int unsigned AW = 8;
    localparam int unsigned OW = 4;
`ifdef PHASE_OFFSET_EN
    localparam int OFF_DIR = 8;
`else
    localparam int OFF_DIR = 0;
`endif

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic          rst, en, clr, valid;
    logic [AW-1:0] ftw;
    logic [OW-1:0] phase_offset;

    logic [AW-1:0] act_o   [2];
    logic [AW-1:0] acc_o   [2];
    logic          wrap_o  [2];
    logic [OW-1:0] ph_o    [2];
    logic          pv_o    [2];

    phase_acc_dds_if #(.ACC_W(AW)) if_w ();
    phase_acc_dds_if #(.ACC_W(AW)) if_i ();

    assign if_w.ftw_in    = ftw;
    assign if_w.ftw_valid = valid;
    assign if_i.ftw_in    = ftw;
    assign if_i.ftw_valid = valid;

    phase_acc_dds #(.ACC_W(AW), .OUT_W(OW), .APPLY_AT_WRAP(1'b1)) dut_w (
        .Clock      (Clock),
        .rst        (rst),
        .en         (en),
        .clr        (clr),
        .ftw_if     (if_w),
`ifdef PHASE_OFFSET_EN
        .phase_offset(phase_offset),
`endif
        .ftw_active (act_o[0]),
        .acc_out    (acc_o[0]),
        .wrap       (wrap_o[0]),
        .phase_out  (ph_o[0]),
        .phase_valid(pv_o[0])
    );

    phase_acc_dds #(.ACC_W(AW), .OUT_W(OW), .APPLY_AT_WRAP(1'b0)) dut_i (
        .Clock      (Clock),
        .rst        (rst),
        .en         (en),
        .clr        (clr),
        .ftw_if     (if_i),
`ifdef PHASE_OFFSET_EN
        .phase_offset(phase_offset),
`endif
        .ftw_active (act_o[1]),
        .acc_out    (acc_o[1]),
        .wrap       (wrap_o[1]),
        .phase_out  (ph_o[1]),
        .phase_valid(pv_o[1])
    );

    int tests = 0;
    int fails = 0;

    // Model state, index 0 = apply at wrap, index 1 = apply immediately.
    int m_acc[2], m_act[2], m_pend[2], m_ph[2];
    bit m_wrap[2], m_busy[2], m_enq[2], m_pv[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int off;
`ifdef PHASE_OFFSET_EN
        off = int'(phase_offset);
`else
        off = 0;
`endif
        for (int m = 0; m < 2; m++) begin
            int sum;
            bit carry;
            if (rst) begin
                m_acc[m] = 0; m_act[m] = 0; m_pend[m] = 0; m_ph[m] = 0;
                m_wrap[m] = 0; m_busy[m] = 0; m_enq[m] = 0; m_pv[m] = 0;
            end else begin
                sum   = m_acc[m] + m_act[m];
                carry = (sum > 255);
                m_ph[m]  = ((m_acc[m] / 16) + off) % 16;
                m_pv[m]  = m_enq[m];
                m_enq[m] = en;
                if (!m_busy[m]) begin
                    if (valid) begin
                        m_pend[m] = int'(ftw);
                        m_busy[m] = 1;
                    end
                end else if (m == 1 || m_act[m] == 0 || (en && !clr && carry)) begin
                    m_act[m]  = m_pend[m];
                    m_busy[m] = 0;
                end
                if (clr) begin
                    m_acc[m] = 0; m_wrap[m] = 0;
                end else if (en) begin
                    m_acc[m] = sum % 256; m_wrap[m] = carry;
                end else begin
                    m_wrap[m] = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            string s;
            logic  rdy;
            s   = (m == 0) ? "wrapmode" : "immmode";
            rdy = (m == 0) ? if_w.ftw_ready : if_i.ftw_ready;
            chk({s, "_acc"}, 32'(acc_o[m]), 32'(m_acc[m]));
            chk({s, "_wrap"}, 32'(wrap_o[m]), 32'(m_wrap[m]));
            chk({s, "_active"}, 32'(act_o[m]), 32'(m_act[m]));
            chk({s, "_ready"}, 32'(rdy), 32'(!m_busy[m]));
            chk({s, "_phase"}, 32'(ph_o[m]), 32'(m_ph[m]));
            chk({s, "_pvalid"}, 32'(pv_o[m]), 32'(m_pv[m]));
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        model_step();
        #1;
        check_all();
    endtask

    function automatic logic [31:0] exp_ph(input int nib);
        return 32'((nib + OFF_DIR) % 16);
    endfunction

    initial begin
        int exp_acc[4];
        exp_acc = '{8'h40, 8'h80, 8'hC0, 8'h00};
        rst = 1; en = 0; clr = 0; valid = 0; ftw = '0; phase_offset = 4'(OFF_DIR);

        // Reset state
        tick(); tick();
        chk("rst_acc", 32'(acc_o[0]), 0);
        chk("rst_ready", 32'(if_w.ftw_ready), 1);
        chk("rst_pvalid", 32'(pv_o[0]), 0);

        // Load 0x40 from IDLE and count through one full revolution
        rst = 0; valid = 1; ftw = 8'h40;
        tick();
        valid = 0;
        tick();
        chk("load_active_w", 32'(act_o[0]), 32'h40);
        chk("load_active_i", 32'(act_o[1]), 32'h40);
        en = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("seq_acc", 32'(acc_o[0]), 32'(exp_acc[k]));
            chk("seq_wrap", 32'(wrap_o[0]), (k == 3) ? 1 : 0);
            if (k >= 1) chk("seq_phase", 32'(ph_o[0]), exp_ph(exp_acc[k-1] / 16));
        end
        tick();
        chk("seq_acc_again", 32'(acc_o[0]), 32'h40);

        // Offer 0x10 at acc=0x40; second offer while busy must be ignored
        valid = 1; ftw = 8'h10;
        tick();
        chk("offer_ready_w", 32'(if_w.ftw_ready), 0);
        chk("offer_acc", 32'(acc_o[0]), 32'h80);
        ftw = 8'h77;
        tick();
        chk("imm_active", 32'(act_o[1]), 32'h10);
        chk("wrap_still_old", 32'(act_o[0]), 32'h40);
        valid = 0;
        tick();
        chk("wrapmode_wrap", 32'(wrap_o[0]), 1);
        chk("wrapmode_swap", 32'(act_o[0]), 32'h10);
        chk("immmode_acc", 32'(acc_o[1]), 32'hD0);
        tick();
        chk("wrapmode_next", 32'(acc_o[0]), 32'h10);
        chk("imm_not_overwritten", 32'(act_o[1]), 32'h10);

        // Zero active FTW: apply-at-wrap must not deadlock
        rst = 1; en = 0;
        tick();
        rst = 0; valid = 1; ftw = 8'h20;
        tick();
        valid = 0;
        tick();
        chk("escape_active", 32'(act_o[0]), 32'h20);
        en = 1;
        tick(); tick();
        chk("escape_step", 32'(acc_o[0]), 32'h40);

        // clr at acc=0xF0 with a pending FTW: cleared, no wrap, pending kept
        rst = 1; en = 0;
        tick();
        rst = 0; valid = 1; ftw = 8'h10;
        tick();
        valid = 0;
        tick();
        en = 1;
        for (int k = 0; k < 14; k++) tick();
        valid = 1; ftw = 8'h20;
        tick();
        chk("pre_clr_acc", 32'(acc_o[0]), 32'hF0);
        valid = 0; clr = 1;
        tick();
        chk("clr_acc", 32'(acc_o[0]), 0);
        chk("clr_wrap", 32'(wrap_o[0]), 0);
        chk("clr_pending_kept", 32'(if_w.ftw_ready), 0);
        chk("clr_active_kept", 32'(act_o[0]), 32'h10);
        clr = 0; en = 0;
        tick();

        // Reset while PENDING drops the pending word
        rst = 1;
        tick();
        chk("rst_pend_ready", 32'(if_w.ftw_ready), 1);
        chk("rst_pend_active", 32'(act_o[0]), 0);
        rst = 0; en = 1;
        tick(); tick(); tick();
        chk("rst_pend_dropped", 32'(act_o[0]), 0);

        // Randomised traffic, including half-scale and all-ones FTWs
        for (int n = 0; n < 600; n++) begin
            int sel;
            rst   = ($urandom_range(0, 63) == 0);
            clr   = ($urandom_range(0, 15) == 0);
            en    = ($urandom_range(0, 3) != 0);
            valid = ($urandom_range(0, 3) == 0);
            sel   = $urandom_range(0, 7);
            ftw   = (sel == 0) ? 8'h80 : (sel == 1) ? 8'hFF : (sel == 2) ? 8'h00 : 8'($urandom);
            phase_offset = 4'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
